avalon_msg_enforcer: RTL and testbench

Parametrised next-generation Avalon-ST framing enforcer placed between an untrusted source and trusted downstream logic. Repairs SOP/EOP framing, masks invalid bytes per `empty`, and truncates over-length messages. Registers its output through a skid buffer so the ready path is timing-isolated. Flags and optionally counts every violation.

---
 rtl/avalon_msg_enforcer_pkg.sv | 11 +
 rtl/avalon_msg_enforcer_if.sv | 13 +
 rtl/avalon_msg_enforcer_skid.sv | 63 ++++++
 rtl/avalon_msg_enforcer.sv | 126 ++++++++++++
 tb/tb_avalon_msg_enforcer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_msg_enforcer_pkg.sv
// general_pack: shared helpers and state type for avalon_msg_enforcer
package general_pack;
    typedef enum logic [1:0] {BETWEEN_MSG, IN_MSG, DRAIN} enforcer_state_t;
    function automatic int log2up_func(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/avalon_msg_enforcer_if.sv
// avalon_st_if: Avalon-ST beat bundle with source (master) and sink (slave) views
interface avalon_st_if
    import general_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16
) ();
    localparam int EMPTY_W = log2up_func(DATA_WIDTH_IN_BYTES);
    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic [EMPTY_W-1:0]               empty;
    logic                             sop, eop, valid, rdy;
    modport master (output data, empty, sop, eop, valid, input rdy);
    modport slave  (input data, empty, sop, eop, valid, output rdy);
endinterface

// File: rtl/avalon_msg_enforcer_skid.sv
// avalon_skid_buffer: 2-entry registered stage; in_rdy comes from a flop so out_rdy never reaches it
module avalon_skid_buffer
    import general_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    localparam int EW = log2up_func(DATA_WIDTH_IN_BYTES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0] in_data,
    input  logic [EW-1:0]                    in_empty,
    input  logic                             in_sop,
    input  logic                             in_eop,
    output logic                             in_rdy,
    output logic                             out_valid,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0] out_data,
    output logic [EW-1:0]                    out_empty,
    output logic                             out_sop,
    output logic                             out_eop,
    input  logic                             out_rdy
);
    localparam int BW = DATA_WIDTH_IN_BYTES*8 + EW + 2;
    logic [BW-1:0] out_q, out_d, skid_q, skid_d, in_beat;
    logic          out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, rdy_q, rdy_d, push;
    assign in_beat = {in_sop, in_eop, in_empty, in_data};
    assign push    = in_valid && rdy_q;
    // refill the output stage from the skid entry first, park new beats in the skid entry while stalled
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || out_rdy) begin
            out_valid_d  = skid_valid_q || push;
            out_d        = skid_valid_q ? skid_q : (push ? in_beat : out_q);
            skid_valid_d = 1'b0;
        end else if (push) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
        rdy_d = !skid_valid_d;
    end
    // storage flops; reset empties both entries and holds off the source
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            rdy_q        <= rdy_d;
        end
    end
    assign in_rdy    = rdy_q;
    assign out_valid = out_valid_q;
    assign {out_sop, out_eop, out_empty, out_data} = out_q;
endmodule

// File: rtl/avalon_msg_enforcer.sv
// avalon_msg_enforcer: repairs Avalon-ST framing, masks empty bytes, truncates long messages; counters under AVALON_ENFORCER_COUNTERS_EN
module avalon_msg_enforcer
    import general_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int MAX_MSG_BEATS       = 256,
    parameter int COUNTER_WIDTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    avalon_st_if.slave               untrusted_msg,
    avalon_st_if.master              enforced_msg,
    output logic                     missing_sop_indi,
    output logic                     unexpected_sop_indi,
    output logic                     truncated_indi,
    input  logic                     cnt_clr,
    output logic [COUNTER_WIDTH-1:0] missing_sop_cnt,
    output logic [COUNTER_WIDTH-1:0] unexpected_sop_cnt,
    output logic [COUNTER_WIDTH-1:0] truncated_cnt
);
    localparam int DW = DATA_WIDTH_IN_BYTES*8;
    localparam int EW = log2up_func(DATA_WIDTH_IN_BYTES);
    localparam int BCW = log2up_func(MAX_MSG_BEATS + 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_MSG_BEATS);

    enforcer_state_t state_q, state_d;
    logic [BCW-1:0]  beat_q, beat_d;
    logic [2:0]      indi_q, indi_d;
    logic            in_rdy, accept, fwd, o_sop, o_eop;
    logic [EW-1:0]   o_empty;
    logic [DW-1:0]   o_data;

    assign accept            = untrusted_msg.valid && in_rdy;
    assign untrusted_msg.rdy = in_rdy;

    // framing FSM: indi_d bits are {truncated, unexpected_sop, missing_sop}
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        indi_d  = '0;
        fwd     = 1'b0;
        o_sop   = untrusted_msg.sop;
        o_eop   = untrusted_msg.eop;
        if (accept) begin
            if (state_q != IN_MSG) begin
                fwd       = untrusted_msg.sop;
                beat_d    = untrusted_msg.sop ? BCW'(1) : beat_q;
                indi_d[0] = !untrusted_msg.sop && state_q == BETWEEN_MSG;
                state_d   = untrusted_msg.sop ? (untrusted_msg.eop ? BETWEEN_MSG : IN_MSG)
                          : (untrusted_msg.eop ? BETWEEN_MSG : state_q);
            end else begin
                fwd       = 1'b1;
                o_sop     = 1'b0;
                beat_d    = beat_q + 1'b1;
                indi_d[1] = untrusted_msg.sop;
                indi_d[2] = !untrusted_msg.eop && beat_d == LAST_BEAT;
                o_eop     = untrusted_msg.eop || indi_d[2];
                state_d   = untrusted_msg.eop ? BETWEEN_MSG : (indi_d[2] ? DRAIN : IN_MSG);
            end
        end
    end

    // only genuine EOP beats keep their empty count; truncated beats carry a full beat
    always_comb begin
        o_empty = untrusted_msg.eop ? untrusted_msg.empty : '0;
        o_data  = untrusted_msg.data;
        for (int i = 0; i < DATA_WIDTH_IN_BYTES; i++)
            o_data[8*i +: 8] = (i < int'(o_empty)) ? 8'h00 : untrusted_msg.data[8*i +: 8];
    end

    // state, beat counter and indicator pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BETWEEN_MSG;
            beat_q  <= '0;
            indi_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            indi_q  <= indi_d;
        end
    end

    assign {truncated_indi, unexpected_sop_indi, missing_sop_indi} = indi_q;

    avalon_skid_buffer #(.DATA_WIDTH_IN_BYTES(DATA_WIDTH_IN_BYTES)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept && fwd),
        .in_data   (o_data),
        .in_empty  (o_empty),
        .in_sop    (o_sop),
        .in_eop    (o_eop),
        .in_rdy    (in_rdy),
        .out_valid (enforced_msg.valid),
        .out_data  (enforced_msg.data),
        .out_empty (enforced_msg.empty),
        .out_sop   (enforced_msg.sop),
        .out_eop   (enforced_msg.eop),
        .out_rdy   (enforced_msg.rdy)
    );

`ifdef AVALON_ENFORCER_COUNTERS_EN
    logic [2:0][COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    // saturating counters stepped alongside the indicator pulses; clear has priority
    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < 3; k++)
            cnt_d[k] = cnt_clr ? '0 : cnt_q[k] + COUNTER_WIDTH'(indi_d[k] && !(&cnt_q[k]));
    end
    // counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign missing_sop_cnt    = cnt_q[0];
    assign unexpected_sop_cnt = cnt_q[1];
    assign truncated_cnt      = cnt_q[2];
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr     = cnt_clr;
    assign missing_sop_cnt    = '0;
    assign unexpected_sop_cnt = '0;
    assign truncated_cnt      = '0;
`endif
endmodule

// File: tb/tb_avalon_msg_enforcer.sv
// tb_avalon_msg_enforcer: randomized and directed checks of avalon_msg_enforcer against a message-level model
module tb_avalon_msg_enforcer;
    import general_pack::*;
    localparam int NB = 16, MAXB = 4, CW = 4;
    localparam int EW = log2up_func(NB);
`ifdef AVALON_ENFORCER_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [NB*8-1:0] data;
        logic [EW-1:0]   empty;
        logic            sop;
        logic            eop;
    } beat_t;

    logic clk = 1'b0, rst = 1'b0, cnt_clr = 1'b0;
    logic missing_sop_indi, unexpected_sop_indi, truncated_indi;
    logic [CW-1:0] missing_sop_cnt, unexpected_sop_cnt, truncated_cnt;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) u_if ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) e_if ();

    avalon_msg_enforcer #(.DATA_WIDTH_IN_BYTES(NB), .MAX_MSG_BEATS(MAXB), .COUNTER_WIDTH(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .untrusted_msg      (u_if.slave),
        .enforced_msg       (e_if.master),
        .missing_sop_indi   (missing_sop_indi),
        .unexpected_sop_indi(unexpected_sop_indi),
        .truncated_indi     (truncated_indi),
        .cnt_clr            (cnt_clr),
        .missing_sop_cnt    (missing_sop_cnt),
        .unexpected_sop_cnt (unexpected_sop_cnt),
        .truncated_cnt      (truncated_cnt)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    beat_t stim[$], expq[$];
    int mode = 0, pos = 0;
    int vld_pct = 100, rdy_pct = 100;
    int mcnt[3] = '{0, 0, 0};
    logic [2:0] exp_ind = '0;
    bit exp_lat = 0, prev_stall = 0, clr_req = 0;
    logic [NB*8+EW+2:0] prev_out;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ecnt(input int k);
        return CNT_EN ? mcnt[k] : 0;
    endfunction

    task automatic add_beat(input bit s, input bit e, input int emp);
        beat_t b;
        b.data  = {$urandom, $urandom, $urandom, $urandom};
        b.empty = EW'(emp);
        b.sop   = s;
        b.eop   = e;
        stim.push_back(b);
    endtask

    // message-level reference: 0 = between messages, 1 = inside one, 2 = discarding a truncated tail
    task automatic model(input beat_t b, output bit fwd);
        beat_t o;
        bit m = 0, u = 0, t = 0;
        o   = b;
        fwd = 0;
        if (mode != 1) begin
            if (b.sop) begin
                fwd  = 1;
                pos  = 1;
                mode = b.eop ? 0 : 1;
            end else if (mode == 0) m = 1;
            else if (b.eop) mode = 0;
        end else begin
            fwd   = 1;
            pos   = pos + 1;
            u     = b.sop;
            t     = !b.eop && pos == MAXB;
            o.sop = 0;
            o.eop = b.eop || t;
            mode  = b.eop ? 0 : (t ? 2 : 1);
        end
        if (fwd) begin
            if (!b.eop) o.empty = '0;
            for (int i = 0; i < NB; i++)
                if (i < int'(o.empty)) o.data[8*i +: 8] = 8'h00;
            expq.push_back(o);
        end
        exp_ind = {t, u, m};
    endtask

    task automatic cycle();
        logic r0;
        bit fire, acc, fwd;
        beat_t b, ob;
        int n;
        @(negedge clk);
        chk("indicators", {truncated_indi, unexpected_sop_indi, missing_sop_indi}, exp_ind);
        chk("missing_cnt", missing_sop_cnt, ecnt(0));
        chk("unexp_cnt", unexpected_sop_cnt, ecnt(1));
        chk("trunc_cnt", truncated_cnt, ecnt(2));
        if (exp_lat) chk("latency_valid", e_if.valid, 1);
        if (prev_stall) chk("stall_stable", {e_if.valid, e_if.sop, e_if.eop, e_if.empty, e_if.data}, prev_out);
        r0 = u_if.rdy;
        e_if.rdy = ($urandom_range(99) < rdy_pct);
        cnt_clr = clr_req;
        clr_req = 0;
        u_if.valid = stim.size() > 0 && ($urandom_range(99) < vld_pct);
        if (stim.size() > 0) begin
            u_if.data  = stim[0].data;
            u_if.empty = stim[0].empty;
            u_if.sop   = stim[0].sop;
            u_if.eop   = stim[0].eop;
        end
        #1;
        chk("rdy_isolated", u_if.rdy, r0);
        fire = e_if.valid && e_if.rdy;
        acc  = u_if.valid && u_if.rdy;
        if (fire) begin
            chk("out_expected", expq.size() > 0, 1);
            if (expq.size() > 0) begin
                ob = expq.pop_front();
                chk("out_beat", {e_if.sop, e_if.eop, e_if.empty, e_if.data}, {ob.sop, ob.eop, ob.empty, ob.data});
            end
        end
        prev_stall = e_if.valid && !e_if.rdy;
        prev_out   = {e_if.valid, e_if.sop, e_if.eop, e_if.empty, e_if.data};
        exp_ind = '0;
        exp_lat = 0;
        if (acc) begin
            b = stim.pop_front();
            n = expq.size();
            model(b, fwd);
            exp_lat = fwd && n == 0;
        end
        for (int k = 0; k < 3; k++)
            mcnt[k] = cnt_clr ? 0 : ((exp_ind[k] && mcnt[k] < (1 << CW) - 1) ? mcnt[k] + 1 : mcnt[k]);
    endtask

    task automatic drain(input int bound);
        int c = 0;
        while ((stim.size() > 0 || expq.size() > 0) && c < bound) begin
            cycle();
            c++;
        end
        chk("drain_in", stim.size(), 0);
        chk("drain_out", expq.size(), 0);
        repeat (3) cycle();
    endtask

    task automatic gen_random(input int nbeats);
        int n = 0;
        int len;
        while (n < nbeats) begin
            len = $urandom_range(1, 7);
            if ($urandom_range(9) == 0) begin
                add_beat(0, $urandom_range(1), $urandom_range(NB - 1));
                n++;
            end
            for (int j = 0; j < len; j++) begin
                add_beat(j == 0 || $urandom_range(9) == 0, j == len - 1, $urandom_range(NB - 1));
                n++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.valid = 0; u_if.data = '0; u_if.empty = '0; u_if.sop = 0; u_if.eop = 0;
        e_if.rdy = 0;
        repeat (3) @(negedge clk);
        chk("rst_out", {e_if.valid, e_if.sop, e_if.eop, e_if.empty, e_if.data}, 0);
        chk("rst_in_rdy", u_if.rdy, 0);
        chk("rst_ind", {truncated_indi, unexpected_sop_indi, missing_sop_indi}, 0);
        chk("rst_cnt", {missing_sop_cnt, unexpected_sop_cnt, truncated_cnt}, 0);
        rst = 1;
        cycle();
        chk("rdy_rise", u_if.rdy, 1);
        // 3-beat message with empty=5 on every beat
        add_beat(1, 0, 5); add_beat(0, 0, 5); add_beat(0, 1, 5);
        drain(50);
        // two beats without sop, then a good message
        add_beat(0, 0, 2); add_beat(0, 1, 3); add_beat(1, 0, 0); add_beat(0, 1, 7);
        drain(50);
        // stray sop inside a message
        add_beat(1, 0, 0); add_beat(1, 0, 0); add_beat(0, 1, 9);
        drain(50);
        // 7-beat message truncated at 4, then a normal one; then exactly 4 beats with eop
        for (int j = 0; j < 7; j++) add_beat(j == 0, j == 6, 4);
        add_beat(1, 0, 0); add_beat(0, 1, 1);
        for (int j = 0; j < 4; j++) add_beat(j == 0, j == 3, 6);
        add_beat(1, 1, 15);
        drain(80);
        // random traffic with 50% output stalls
        vld_pct = 70; rdy_pct = 50;
        gen_random(1000);
        drain(20000);
        // reset with two beats buffered under a full stall
        vld_pct = 100; rdy_pct = 0;
        add_beat(1, 0, 0); add_beat(0, 0, 0); add_beat(0, 0, 0); add_beat(0, 1, 0);
        repeat (4) cycle();
        @(posedge clk);
        #2 rst = 0;
        #1;
        chk("mid_rst_out", {e_if.valid, e_if.sop, e_if.eop, e_if.empty, e_if.data}, 0);
        chk("mid_rst_rdy", u_if.rdy, 0);
        stim.delete(); expq.delete();
        mode = 0; pos = 0; exp_ind = '0; exp_lat = 0; prev_stall = 0;
        for (int k = 0; k < 3; k++) mcnt[k] = 0;
        @(negedge clk);
        rst = 1;
        rdy_pct = 100;
        cycle();
        chk("rdy_rise2", u_if.rdy, 1);
        add_beat(0, 0, 3);
        drain(20);
        // saturate missing-sop counter, then clear it
        for (int j = 0; j < 20; j++) add_beat(0, 0, 0);
        drain(60);
        clr_req = 1;
        repeat (2) cycle();
        add_beat(1, 0, 0); add_beat(0, 1, 2);
        drain(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
